// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel gradient magnitude over an 8-bit luma stream, fixed 3-clock latency.
// Optional build macro SOBEL_THRESH_EN binarizes the magnitude against THRESH.
module sobel_edge #(
    parameter int LINE_W     = 1024,
    parameter int COLORDEPTH = 8,
    parameter int THRESH     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] y_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic                  line_end_i,
    output logic [7:0]            edge_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o
);
    localparam int            PW      = COLORDEPTH;
    localparam int            CW      = $clog2(LINE_W);
    localparam logic [CW-1:0] COL_MAX = CW'(LINE_W - 1);
    localparam logic [10:0]   ROW_MAX = 11'd2047;

    function automatic logic signed [10:0] tap_sum(input logic [7:0] a,
                                                   input logic [7:0] b,
                                                   input logic [7:0] c);
        return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        logic [10:0] u;
        u = v;
        return u[10] ? (~u + 11'd1) : u;
    endfunction

    logic [PW-1:0]            r_lb0 [LINE_W];
    logic [PW-1:0]            r_lb1 [LINE_W];
    logic [CW-1:0]            r_col;
    logic                     r_col_ovf;
    logic [10:0]              r_row;
    logic                     r_dv_d;
    logic                     r_vs_d;
    logic [2:0][2:0][PW-1:0]  r_win;
    logic                     r_m1;
    logic                     r_m2;
    logic [2:0]               r_sync1;
    logic [2:0]               r_sync2;
    logic signed [10:0]       r_gx;
    logic signed [10:0]       r_gy;

    logic [CW-1:0]            w_col;
    logic                     w_ovf;
    logic                     w_col_last;
    logic                     w_vs_rise;
    logic                     w_dv_fall;
    logic [10:0]              w_row;
    logic                     w_wr_en;
    logic [PW-1:0]            w_up1;
    logic [PW-1:0]            w_up2;
    logic signed [10:0]       w_gx;
    logic signed [10:0]       w_gy;
    logic [11:0]              w_mag;
    logic [7:0]               w_lvl;

    // Position of the current sample; line_end_i and a vsync edge take effect on the same cycle.
    always_comb begin
        w_col      = line_end_i ? {CW{1'b0}} : r_col;
        w_ovf      = line_end_i ? 1'b0 : r_col_ovf;
        w_col_last = (w_col == COL_MAX);
        w_vs_rise  = vs_i & ~r_vs_d;
        w_dv_fall  = ~dv_i & r_dv_d;
        w_row      = w_vs_rise ? 11'd0 : r_row;
        w_wr_en    = dv_i & ~w_ovf;
        w_up1      = r_lb0[w_col];
        w_up2      = r_lb1[w_col];
    end

    // Line buffers: lb0 carries row r-1, lb1 row r-2; the old word is read before it is replaced.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_lb0[w_col] <= y_i;
            r_lb1[w_col] <= w_up1;
        end
    end

    // Column counter with an overflow flag for pixels past the buffer, and the row counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= {CW{1'b0}};
            r_col_ovf <= 1'b0;
            r_row     <= 11'd0;
            r_dv_d    <= 1'b0;
            r_vs_d    <= 1'b0;
        end else begin
            r_dv_d <= dv_i;
            r_vs_d <= vs_i;
            if (dv_i) begin
                r_col     <= w_col_last ? w_col : w_col + CW'(1);
                r_col_ovf <= w_ovf | w_col_last;
            end else begin
                r_col     <= w_col;
                r_col_ovf <= w_ovf;
            end
            if (w_vs_rise) begin
                r_row <= 11'd0;
            end else if (w_dv_fall && (r_row != ROW_MAX)) begin
                r_row <= r_row + 11'd1;
            end else begin
                r_row <= r_row;
            end
        end
    end

    // Gradients of the registered window; p[row][col] with row 0 oldest and col 2 newest.
    always_comb begin
        w_gx = tap_sum(r_win[0][2], r_win[1][2], r_win[2][2])
             - tap_sum(r_win[0][0], r_win[1][0], r_win[2][0]);
        w_gy = tap_sum(r_win[2][0], r_win[2][1], r_win[2][2])
             - tap_sum(r_win[0][0], r_win[0][1], r_win[0][2]);
    end

    // Magnitude and output level.
    always_comb begin
        w_mag = {1'b0, abs11(r_gx)} + {1'b0, abs11(r_gy)};
`ifdef SOBEL_THRESH_EN
        w_lvl = (w_mag >= 12'(THRESH)) ? 8'hFF : 8'h00;
`else
        w_lvl = (w_mag > 12'd255) ? 8'hFF : w_mag[7:0];
`endif
    end

`ifndef SOBEL_THRESH_EN
    logic [31:0] w_unused_thresh;
    assign w_unused_thresh = THRESH;
`endif

    // S1 window shift and border mask, S2 gradient registers, S3 output; sync bits ride alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win   <= {(9*PW){1'b0}};
            r_m1    <= 1'b0;
            r_m2    <= 1'b0;
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_gx    <= 11'sd0;
            r_gy    <= 11'sd0;
            edge_o  <= 8'h00;
            dv_o    <= 1'b0;
            hs_o    <= 1'b0;
            vs_o    <= 1'b0;
        end else begin
            if (dv_i) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_up2;
                r_win[1][2] <= w_up1;
                r_win[2][2] <= y_i;
            end else begin
                r_win <= r_win;
            end
            r_m1    <= dv_i & ~w_ovf & (w_col >= CW'(2)) & (w_row >= 11'd2);
            r_sync1 <= {dv_i, hs_i, vs_i};
            r_gx    <= w_gx;
            r_gy    <= w_gy;
            r_m2    <= r_m1;
            r_sync2 <= r_sync1;
            edge_o  <= r_m2 ? w_lvl : 8'h00;
            {dv_o, hs_o, vs_o} <= r_sync2;
        end
    end
endmodule

// File: tb/tb_sobel_edge.sv
// Self-checking bench for sobel_edge: directed pattern table, reset/overlong-line sequences,
// and random frames compared cycle by cycle against an image-level Sobel model.
module tb_sobel_edge;
    localparam int LW   = 16;
    localparam int NCYC = 20000;
    localparam int NV   = 19;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] y_i;
    logic       dv_i, hs_i, vs_i, line_end_i;
    logic [7:0] edge_o;
    logic       dv_o, hs_o, vs_o;

    always #5 clk = ~clk;

    sobel_edge #(.LINE_W(LW), .COLORDEPTH(8), .THRESH(64)) dut (
        .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .line_end_i(line_end_i), .edge_o(edge_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    typedef struct {
        int pat;
        int lvl;
        int r;
        int c;
        int mag;
    } vec_t;

    vec_t        tbl [NV];
    logic [7:0]  img [16][24];
    logic [7:0]  cap [16][24];
    logic [10:0] e_out [NCYC];
    int          t_r [NCYC];
    int          t_c [NCYC];
    int          n = 0;
    int          n_pass = 0;
    int          n_chk = 0;

    function automatic int exp_of(input int mag);
`ifdef SOBEL_THRESH_EN
        return (mag >= 64) ? 255 : 0;
`else
        return (mag > 255) ? 255 : mag;
`endif
    endfunction

    // Sobel on the stored image, centred one row up and one column left of the sample.
    function automatic int model_edge(input logic dv, input int r, input int c);
        int gx, gy, wgt;
        if (!dv || r < 2 || c < 2 || c >= LW) return 0;
        gx = 0;
        gy = 0;
        for (int k = 0; k < 3; k++) begin
            wgt = (k == 1) ? 2 : 1;
            gx += wgt * (int'(img[r-2+k][c]) - int'(img[r-2+k][c-2]));
            gy += wgt * (int'(img[r][c-2+k]) - int'(img[r-2][c-2+k]));
        end
        return exp_of(((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc(input logic [7:0] y, input logic dv, input logic hs, input logic vs,
                       input logic le, input logic rs, input int r, input int c);
        int m;
        if (n >= NCYC) begin
            $display("FAIL cycle_budget: got %0d, expected below %0d", n, NCYC);
            $fatal(1, "cycle budget exhausted");
        end
        y_i = y; dv_i = dv; hs_i = hs; vs_i = vs; line_end_i = le; rst = rs;
        t_r[n]   = rs ? -1 : r;
        t_c[n]   = c;
        e_out[n] = {8'(model_edge(dv, r, c)), dv, hs, vs};
        if (rs) begin
            for (int k = n - 2; k <= n; k++) if (k >= 0) e_out[k] = 11'd0;
        end
        @(posedge clk);
        #1;
        if (n >= 2) begin
            m = n - 2;
            chk($sformatf("cycle%0d", m), int'({edge_o, dv_o, hs_o, vs_o}), int'(e_out[m]));
            if (t_r[m] >= 0) cap[t_r[m]][t_c[m]] = edge_o;
        end
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic build_img(input int pat, input int lvl);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 24; c++)
                case (pat)
                    0:       img[r][c] = 8'(lvl);
                    1:       img[r][c] = (c >= 4) ? 8'(lvl) : 8'd0;
                    2:       img[r][c] = (r >= 4) ? 8'(lvl) : 8'd0;
                    3:       img[r][c] = (c == 15) ? 8'd40 : ((c > 15) ? 8'd10 : 8'd0);
                    default: img[r][c] = 8'($urandom_range(0, 255));
                endcase
    endtask

    // rst_row >= 0 aborts the frame with a one-cycle reset in the middle of that line.
    task automatic run_frame(input int h, input int w, input bit tight, input int rst_row);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 24; c++) cap[r][c] = 8'hAA;
        for (int i = 0; i < 3; i++) cyc(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
        idle(2);
        for (int r = 0; r < h; r++) begin
            cyc(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
            cyc(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
            cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
            for (int c = 0; c < w; c++) begin
                if (r == rst_row && c == w / 2) begin
                    cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
                    chk("post_rst_outputs", int'({edge_o, dv_o, hs_o, vs_o}), 0);
                    return;
                end
                cyc(img[r][c], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r, c);
            end
            if (!(tight && r == h - 1)) idle(2);
        end
    endtask

    initial begin
        int cur_pat, cur_lvl, h, w;
        tbl[0]  = '{0, 80, 2, 2, 0};
        tbl[1]  = '{0, 80, 5, 5, 0};
        tbl[2]  = '{0, 80, 7, 7, 0};
        tbl[3]  = '{1, 20, 4, 4, 80};
        tbl[4]  = '{1, 20, 4, 5, 80};
        tbl[5]  = '{1, 20, 6, 4, 80};
        tbl[6]  = '{1, 20, 2, 4, 80};
        tbl[7]  = '{1, 20, 1, 4, 0};
        tbl[8]  = '{1, 20, 4, 3, 0};
        tbl[9]  = '{1, 20, 4, 6, 0};
        tbl[10] = '{1, 100, 3, 4, 400};
        tbl[11] = '{1, 100, 5, 5, 400};
        tbl[12] = '{1, 100, 5, 6, 0};
        tbl[13] = '{2, 30, 4, 3, 120};
        tbl[14] = '{2, 30, 5, 6, 120};
        tbl[15] = '{2, 30, 4, 2, 120};
        tbl[16] = '{2, 30, 4, 1, 0};
        tbl[17] = '{2, 30, 3, 4, 0};
        tbl[18] = '{2, 30, 6, 4, 0};

        cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        chk("reset_state", int'({edge_o, dv_o, hs_o, vs_o}), 0);
        cyc(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(2);

        cur_pat = -1;
        cur_lvl = -1;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].pat != cur_pat || tbl[i].lvl != cur_lvl) begin
                build_img(tbl[i].pat, tbl[i].lvl);
                run_frame(8, 8, 1'b0, -1);
                idle(3);
                cur_pat = tbl[i].pat;
                cur_lvl = tbl[i].lvl;
            end
            chk($sformatf("table%0d_r%0d_c%0d", i, tbl[i].r, tbl[i].c),
                int'(cap[tbl[i].r][tbl[i].c]), exp_of(tbl[i].mag));
        end

        // Lines longer than the buffer: columns 16..19 masked, the next line unaffected.
        build_img(3, 0);
        run_frame(6, 20, 1'b0, -1);
        idle(3);
        chk("wide_r4_c15", int'(cap[4][15]), exp_of(160));
        chk("wide_r4_c16", int'(cap[4][16]), 0);
        chk("wide_r4_c19", int'(cap[4][19]), 0);
        chk("wide_r5_c15", int'(cap[5][15]), exp_of(160));

        // Reset in the middle of line 5, then a flat frame must show no stale data.
        build_img(1, 100);
        run_frame(8, 8, 1'b0, 5);
        idle(3);
        build_img(0, 80);
        run_frame(8, 8, 1'b0, -1);
        idle(3);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                chk($sformatf("flat_after_rst_r%0d_c%0d", r, c), int'(cap[r][c]), 0);

        // Random frames; a tight end makes dv fall on the same cycle vsync rises.
        for (int f = 0; f < 12; f++) begin
            h = $urandom_range(3, 10);
            w = $urandom_range(3, 20);
            build_img(9, 0);
            run_frame(h, w, 1'($urandom_range(0, 1)), -1);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sobel_edge.md
Name: sobel_edge

Overview:
- Consumes the 8-bit luma stream (pixel, dv, hs, vs, line_end) from the RGB-to-luma stage. Emits a 3x3 Sobel gradient magnitude stream with matching sync signals.
- Two internal line buffers build the 3x3 window. Output is luma-domain 8-bit and feeds the display/overlay path.

Parameters:
- LINE_W, 1024, maximum active pixels per line; sets line buffer depth and column counter width clog2(LINE_W).
- COLORDEPTH, 8, luma sample width. Only 8 is supported.
- THRESH, 64, binarization threshold; used only when SOBEL_THRESH_EN is defined.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- y_i  in  8  luma sample, valid when dv_i=1
- dv_i  in  1  data valid
- hs_i  in  1  hsync
- vs_i  in  1  vsync
- line_end_i  in  1  one-cycle pulse at start of each active line; restarts the column counter
- edge_o  out  8  gradient magnitude or binarized edge
- dv_o  out  1  dv_i delayed 3 cycles
- hs_o  out  1  hs_i delayed 3 cycles
- vs_o  out  1  vs_i delayed 3 cycles

Behaviour:
- Reset: one clock, rst synchronous active-high.
  - edge_o, dv_o, hs_o, vs_o, col/row counters, window registers and delay pipes all go to 0.
  - Line buffer RAM contents are not cleared; stale data is hidden by border masking.
- Counters:
  - col_cnt clears on line_end_i. It increments on each dv_i=1 cycle and saturates at LINE_W-1.
  - row_cnt clears on the vs_i rising edge. It increments on the dv_i falling edge and saturates at 2047.
  - If vs_i rises and dv_i falls in the same cycle, the clear wins.
- Line buffers:
  - On dv_i=1 with col_cnt<LINE_W: read lb0/lb1 at col_cnt, write lb0<=y_i and lb1<=lb0 old value, giving rows r-1 and r-2.
  - Read-during-write returns old data.
  - Pixels with col beyond LINE_W-1 are not written and produce edge_o=0.
- Window:
  - 3x3 shift register, columns shift left on dv_i=1 only.
  - Window holds in blanking.
- Pipeline, fixed latency 3 clocks from input to edge_o/dv_o/hs_o/vs_o:
  - S1: window update.
  - S2: Gx=(p02+2p12+p22)-(p00+2p10+p20) and Gy=(p20+2p21+p22)-(p00+2p01+p02), each 11-bit signed.
  - S3: mag=|Gx|+|Gy| (12-bit unsigned, max 2040), saturated to 255 and registered into edge_o.
- Spatial alignment: the output at input position (r,c) is the window centred on (r-1,c-1), i.e. the image is shifted one row and one column.
- Masking:
  - edge_o=0 when the S3-aligned dv is 0.
  - edge_o=0 when the row index of that sample is <2, the column index is <2, or the column is beyond LINE_W-1.
- Reset mid-frame: the pipeline and counters restart. The first 2 rows after vs_i rises again output 0.
- No backpressure; the block accepts every cycle.

Optional Feature:
- Macro SOBEL_THRESH_EN.
- Defined: S3 outputs 255 if mag>=THRESH, else 0. Masking still forces 0.
- Undefined: edge_o = saturated mag; THRESH is unused.
- Latency is 3 clocks in both builds.

Test Plan:
- Flat frame, y_i=80 everywhere, 8x8 frame, LINE_W=16 -> edge_o=0 on all pixels; dv_o/hs_o/vs_o equal the inputs shifted exactly 3 clocks.
- Vertical step, columns 0..3 =0 and columns 4..7 =20 -> interior rows show edge_o=80 at output columns 4 and 5, 0 elsewhere; rows 0-1 and columns 0-1 are 0.
- Vertical step 0/100 -> Gx=400 saturates, edge_o=255 at output columns 4,5; with SOBEL_THRESH_EN and THRESH=64 the same pixels give 255, the rest 0.
- Horizontal step, rows 0..3 =0 and rows 4..7 =30 -> edge_o=120 on output rows 4,5 for interior columns.
- Assert rst for 1 cycle mid-line 5, then restart with vs_i -> all outputs 0 the cycle after rst; the next frame reproduces the flat-frame result with no stale line data visible.
- Line of 20 pixels with LINE_W=16 -> columns 16..19 output 0; the next line still processes correctly after line_end_i.
